// File: rtl/bht_ckpt_writer_pkg.sv
// Shared types for the BHT checkpoint writer: entry packing constants, FSM states
// and the D-cache store port structs.
package bht_ckpt_writer_pkg;

    localparam int CKPT_ENTRY_BITS       = 3;
    localparam int CKPT_ENTRIES_PER_WORD = 21;
    localparam int DCACHE_INDEX_WIDTH    = 12;
    localparam int DCACHE_TAG_WIDTH      = 44;

    typedef enum logic [1:0] {
        CKPT_IDLE,
        CKPT_GATHER,
        CKPT_WRITE,
        CKPT_DONE
    } bht_ckpt_state_e;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

    function automatic int ceil_div(int a, int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/bht_ckpt_writer_if.sv
// D-cache store port between the checkpoint writer (master) and the cache (slave).
interface bht_ckpt_writer_if;
    import bht_ckpt_writer_pkg::*;

    dcache_req_i_t dcache_req;
    dcache_req_o_t dcache_rsp;

    modport master (output dcache_req, input dcache_rsp);
    modport slave  (input dcache_req, output dcache_rsp);
endinterface

// File: rtl/bht_ckpt_writer.sv
// Streams every BHT entry into 64-bit words (21 x 3-bit entries each) and stores
// them to consecutive doublewords starting at an aligned base address.
//   state  | meaning
//   IDLE   | waiting for start_i
//   GATHER | reading one entry per cycle into word_buf
//   WRITE  | store request held until granted
//   DONE   | one-cycle completion pulse
module bht_ckpt_writer
    import bht_ckpt_writer_pkg::*;
#(
    parameter int NR_ENTRIES       = 1024,
    parameter int ENTRIES_PER_WORD = CKPT_ENTRIES_PER_WORD
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [63:0]                   base_addr_i,
    output logic [$clog2(NR_ENTRIES)-1:0] entry_idx_o,
    input  logic [CKPT_ENTRY_BITS-1:0]    entry_i,
    bht_ckpt_writer_if.master             dc,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int IDX_W    = $clog2(NR_ENTRIES);
    localparam int CNT_W    = $clog2(NR_ENTRIES + 1);
    localparam int NR_WORDS = ceil_div(NR_ENTRIES, ENTRIES_PER_WORD);
    localparam int WCNT_W   = $clog2(NR_WORDS + 1);
    localparam int SLOT_W   = $clog2(ENTRIES_PER_WORD);

    localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(ENTRIES_PER_WORD - 1);
    localparam logic [CNT_W-1:0]  LAST_ENTRY  = CNT_W'(NR_ENTRIES - 1);
    localparam logic [CNT_W-1:0]  ALL_ENTRIES = CNT_W'(NR_ENTRIES);

    bht_ckpt_state_e    state_q, state_d;
    logic [63:0]        base_q, base_d;
    logic [CNT_W-1:0]   entry_cnt_q, entry_cnt_d;
    logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [63:0]        word_buf_q, word_buf_d;
    logic               abort_q, abort_d;
    logic [63:0]        st_addr;
    dcache_req_i_t      req;
    logic               unused_bits;

    assign st_addr     = base_q + (64'(word_cnt_q) << 3);
    assign busy_o      = (state_q != CKPT_IDLE);
    assign dc.dcache_req = req;
    assign unused_bits = ^{base_addr_i[2:0], dc.dcache_rsp.data_rvalid, dc.dcache_rsp.data_rdata,
                           st_addr[63:DCACHE_INDEX_WIDTH+DCACHE_TAG_WIDTH]};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= CKPT_IDLE;
            base_q      <= '0;
            entry_cnt_q <= '0;
            word_cnt_q  <= '0;
            slot_q      <= '0;
            word_buf_q  <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            entry_cnt_q <= entry_cnt_d;
            word_cnt_q  <= word_cnt_d;
            slot_q      <= slot_d;
            word_buf_q  <= word_buf_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        entry_cnt_d = entry_cnt_q;
        word_cnt_d  = word_cnt_q;
        slot_d      = slot_q;
        word_buf_d  = word_buf_q;
        abort_d     = abort_q;
        req         = '0;
        entry_idx_o = '0;
        done_o      = 1'b0;

        case (state_q)
            CKPT_IDLE: begin
                if (start_i) begin
                    base_d      = {base_addr_i[63:3], 3'b000};
                    entry_cnt_d = '0;
                    word_cnt_d  = '0;
                    slot_d      = '0;
                    word_buf_d  = '0;
                    abort_d     = 1'b0;
                    state_d     = CKPT_GATHER;
                end
            end
            CKPT_GATHER: begin
                entry_idx_o = entry_cnt_q[IDX_W-1:0];
                if (abort_i) begin
                    state_d = CKPT_IDLE;
                end else begin
                    word_buf_d  = word_buf_q | (64'(entry_i) << (CKPT_ENTRY_BITS * 32'(slot_q)));
                    entry_cnt_d = entry_cnt_q + 1'b1;
                    slot_d      = slot_q + 1'b1;
                    if (slot_q == LAST_SLOT || entry_cnt_q == LAST_ENTRY) begin
                        state_d = CKPT_WRITE;
                    end
                end
            end
            CKPT_WRITE: begin
                req.address_index = st_addr[DCACHE_INDEX_WIDTH-1:0];
                req.address_tag   = st_addr[DCACHE_INDEX_WIDTH +: DCACHE_TAG_WIDTH];
                req.data_wdata    = word_buf_q;
                req.data_req      = 1'b1;
                req.data_we       = 1'b1;
                req.data_be       = 8'hFF;
                req.data_size     = 2'b11;
                req.kill_req      = 1'b0;
                req.tag_valid     = 1'b1;
                if (abort_i) begin
                    abort_d = 1'b1;
                end
                // An abort only lands once the outstanding store has been accepted.
                if (dc.dcache_rsp.data_gnt) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    slot_d     = '0;
                    word_buf_d = '0;
                    abort_d    = 1'b0;
                    if (abort_q || abort_i) begin
                        state_d = CKPT_IDLE;
                    end else if (entry_cnt_q == ALL_ENTRIES) begin
                        state_d = CKPT_DONE;
                    end else begin
                        state_d = CKPT_GATHER;
                    end
                end
            end
            CKPT_DONE: begin
                done_o  = !abort_i;
                state_d = CKPT_IDLE;
            end
            default: state_d = CKPT_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bht_ckpt_writer.sv
// Directed bench for bht_ckpt_writer: full runs, delayed grant, aborts, restart and reset.
module tb_bht_ckpt_writer;
    import bht_ckpt_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        gnt;
    logic        pat_mode;
    logic [63:0] base_addr;
    logic [9:0]  entry_idx;
    logic [2:0]  entry;
    logic        busy;
    logic        done;

    int gnt_delay = 0;
    int wait_cnt;
    int done_cnt;
    int stab_err;
    int n_checks = 0;
    int n_pass   = 0;
    bit wait_v;
    dcache_req_i_t prev_req;
    dcache_req_i_t first_req;
    logic [63:0] st_addr[$];
    logic [63:0] st_data[$];

    always #5 clk = ~clk;

    bht_ckpt_writer_if dc_if();
    assign dc_if.dcache_rsp = dcache_req_o_t'{data_gnt: gnt, data_rvalid: 1'b0, data_rdata: 64'd0};

    bht_ckpt_writer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .base_addr_i (base_addr),
        .entry_idx_o (entry_idx),
        .entry_i     (entry),
        .dc          (dc_if),
        .busy_o      (busy),
        .done_o      (done)
    );

    always_comb entry = pat_mode ? entry_idx[2:0] : 3'b110;

    function automatic logic [63:0] req_addr();
        return {8'd0, dc_if.dcache_req.address_tag, dc_if.dcache_req.address_index};
    endfunction

    function automatic logic [63:0] exp_word(int w, logic pat);
        logic [63:0] r = '0;
        int          idx;
        logic [2:0]  v;
        for (int s = 0; s < 21; s++) begin
            idx = w * 21 + s;
            if (idx < 1024) begin
                v = pat ? idx[2:0] : 3'b110;
                r = r | (64'(v) << (3 * s));
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] get_data(int i);
        return (i < st_data.size()) ? st_data[i] : 64'd0;
    endfunction

    function automatic logic [63:0] get_addr(int i);
        return (i < st_addr.size()) ? st_addr[i] : 64'd0;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Grant driver and store/done monitor, all evaluated on the falling edge.
    initial begin
        gnt = 1'b0; wait_cnt = 0; wait_v = 1'b0; done_cnt = 0; stab_err = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && dc_if.dcache_req.data_req) begin
                if (wait_v && dc_if.dcache_req != prev_req) stab_err++;
                if (wait_cnt >= gnt_delay) begin
                    gnt = 1'b1;
                    if (st_addr.size() == 0) first_req = dc_if.dcache_req;
                    st_addr.push_back(req_addr());
                    st_data.push_back(dc_if.dcache_req.data_wdata);
                    wait_cnt = 0;
                    wait_v   = 1'b0;
                end else begin
                    gnt      = 1'b0;
                    prev_req = dc_if.dcache_req;
                    wait_v   = 1'b1;
                    wait_cnt++;
                end
            end else begin
                gnt = 1'b0; wait_cnt = 0; wait_v = 1'b0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_log();
        st_addr.delete(); st_data.delete(); done_cnt = 0; stab_err = 0;
    endtask

    task automatic start_pulse(input logic [63:0] b);
        base_addr = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 4000) begin @(negedge clk); n++; end
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin @(negedge clk); n++; end
    endtask

    task automatic wait_idx(input int idx, output int n);
        n = 0;
        while (entry_idx != idx[9:0] && n < 3000) begin @(negedge clk); n++; end
    endtask

    task automatic wait_req(input logic [63:0] a, output bit seen);
        int n = 0;
        while (!(dc_if.dcache_req.data_req && req_addr() == a) && n < 3000) begin
            @(negedge clk); n++;
        end
        seen = dc_if.dcache_req.data_req && req_addr() == a;
    endtask

    task automatic check_stores(input string tag, input logic [63:0] b, input logic pat, input int nexp);
        int errs = 0;
        check_val({tag, "_nstores"}, 64'(st_addr.size()), 64'(nexp));
        for (int w = 0; w < st_addr.size(); w++) begin
            if (st_addr[w] != b + 64'(w * 8)) errs++;
            if (st_data[w] != exp_word(w, pat)) errs++;
        end
        check_val({tag, "_store_errs"}, 64'(errs), 64'd0);
    endtask

    initial begin
        int n, n0, n1;
        bit seen;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; pat_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_req_zero", 64'(|dc_if.dcache_req), 64'd0);
        check_val("rst_idx", 64'(entry_idx), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full checkpoint, immediate grant
        clear_log(); gnt_delay = 0; pat_mode = 1'b0;
        start_pulse(64'h8000_0000);
        check_val("s1_gather_busy", 64'(busy), 64'd1);
        check_val("s1_gather_req_zero", 64'(|dc_if.dcache_req), 64'd0);
        check_val("s1_gather_idx0", 64'(entry_idx), 64'd0);
        wait_done(n);
        check_val("s1_done_seen", 64'(done), 64'd1);
        check_val("s1_cycles", 64'(n), 64'd1073);
        @(negedge clk);
        check_val("s1_done_pulse", 64'(done), 64'd0);
        check_val("s1_idle", 64'(busy), 64'd0);
        check_val("s1_done_cnt", 64'(done_cnt), 64'd1);
        check_val("s1_word0", get_data(0), 64'h6DB6_DB6D_B6DB_6DB6);
        check_val("s1_word47", get_data(47), 64'h6DB6_DB6D_B6DB_6DB6);
        check_val("s1_word48", get_data(48), 64'h0000_DB6D_B6DB_6DB6);
        check_val("s1_first_addr", get_addr(0), 64'h8000_0000);
        check_val("s1_last_addr", get_addr(48), 64'h8000_0180);
        check_val("s1_req_fields",
                  64'({first_req.data_we, first_req.data_be, first_req.data_size,
                       first_req.kill_req, first_req.tag_valid}),
                  64'({1'b1, 8'hFF, 2'b11, 1'b0, 1'b1}));
        check_stores("s1", 64'h8000_0000, 1'b0, 49);

        // Delayed grant: 5 withheld cycles per store
        clear_log(); gnt_delay = 5;
        start_pulse(64'h8000_0000);
        wait_done(n);
        check_val("s2_cycles", 64'(n), 64'(1024 + 49 * 6));
        @(negedge clk);
        check_val("s2_stable", 64'(stab_err), 64'd0);
        check_val("s2_word48", get_data(48), 64'h0000_DB6D_B6DB_6DB6);
        check_stores("s2", 64'h8000_0000, 1'b0, 49);

        // Unaligned base, index-dependent entries
        clear_log(); gnt_delay = 0; pat_mode = 1'b1;
        start_pulse(64'h1007);
        wait_done(n);
        @(negedge clk);
        check_val("s3_first_addr", get_addr(0), 64'h1000);
        check_stores("s3", 64'h1000, 1'b1, 49);

        // Abort in GATHER at entry 100
        clear_log(); pat_mode = 1'b0;
        start_pulse(64'h8000_0000);
        wait_idx(100, n);
        check_val("s4_reached_idx", 64'(entry_idx), 64'd100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("s4_idle", 64'(busy), 64'd0);
        repeat (30) @(negedge clk);
        check_val("s4_nstores", 64'(st_addr.size()), 64'd4);
        check_val("s4_no_done", 64'(done_cnt), 64'd0);
        check_val("s4_req_zero", 64'(|dc_if.dcache_req), 64'd0);

        // Abort during WRITE of word 3
        clear_log(); gnt_delay = 5;
        start_pulse(64'h8000_0000);
        wait_req(64'h8000_0018, seen);
        check_val("s5_req_seen", 64'(seen), 64'd1);
        check_val("s5_write_idx0", 64'(entry_idx), 64'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("s5_held_busy", 64'(busy), 64'd1);
        check_val("s5_held_req", 64'(dc_if.dcache_req.data_req), 64'd1);
        wait_idle(50);
        check_val("s5_idle", 64'(busy), 64'd0);
        check_val("s5_nstores", 64'(st_addr.size()), 64'd4);
        check_val("s5_last_addr", get_addr(3), 64'h8000_0018);
        check_val("s5_no_done", 64'(done_cnt), 64'd0);
        check_val("s5_stable", 64'(stab_err), 64'd0);

        // Abort on the final grant cycle
        clear_log(); gnt_delay = 0;
        start_pulse(64'h8000_0000);
        wait_req(64'h8000_0180, seen);
        check_val("s6_req_seen", 64'(seen), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("s6_idle", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check_val("s6_no_done", 64'(done_cnt), 64'd0);
        check_val("s6_nstores", 64'(st_addr.size()), 64'd49);

        // Start pulse while busy is ignored
        clear_log();
        start_pulse(64'h8000_0000);
        wait_idx(500, n0);
        base_addr = 64'h4000; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n0++;
        wait_done(n1);
        check_val("s7_cycles", 64'(n0 + n1), 64'd1073);
        @(negedge clk);
        check_stores("s7", 64'h8000_0000, 1'b0, 49);

        // Reset during WRITE, then a clean checkpoint
        clear_log(); gnt_delay = 5;
        start_pulse(64'h8000_0000);
        wait_req(64'h8000_0010, seen);
        check_val("s8_req_seen", 64'(seen), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("s8_req_dropped", 64'(dc_if.dcache_req.data_req), 64'd0);
        check_val("s8_idle", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log(); gnt_delay = 0; pat_mode = 1'b1;
        start_pulse(64'h2000);
        wait_done(n);
        check_val("s8_cycles", 64'(n), 64'd1073);
        @(negedge clk);
        check_stores("s8", 64'h2000, 1'b1, 49);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bht_ckpt_writer.md
BHT_CKPT_WRITER -- requirements
Module: bht_ckpt_writer

Interface
REQ-001 Parameter NR_ENTRIES, default 1024: number of BHT entries to checkpoint.
REQ-002 Parameter ENTRIES_PER_WORD, default 21: number of 3-bit entries packed per 64-bit store.
REQ-003 clk_i  in  1: the single clock.
REQ-004 rst_ni  in  1: reset, synchronous and active-low.
REQ-005 start_i  in  1: one-cycle pulse that begins a checkpoint.
REQ-006 abort_i  in  1: cancels an in-progress checkpoint.
REQ-007 base_addr_i  in  64: physical base address of the checkpoint area.
REQ-008 entry_idx_o  out  $clog2(NR_ENTRIES): BHT entry index being read.
REQ-009 entry_i  in  3: {valid, saturation_counter[1:0]} of entry_idx_o, same-cycle combinational read.
REQ-010 dcache_req_o  out  ariane_pkg::dcache_req_i_t: store request to the D-cache port.
REQ-011 dcache_rsp_i  in  ariane_pkg::dcache_req_o_t: only data_gnt is used.
REQ-012 busy_o  out  1: high in every state except IDLE.
REQ-013 done_o  out  1: one-cycle pulse, consumed by the CSR to clear the checkpoint-enable bit.

Function
REQ-014 FSM states SHALL be IDLE, GATHER, WRITE and DONE.
REQ-015 In IDLE, start_i SHALL latch {base_addr_i[63:3], 3'b000} and clear entry_cnt, word_cnt, slot and word_buf; the next state is GATHER.
REQ-016 In any state other than IDLE, start_i SHALL be ignored.
REQ-017 In GATHER, each cycle SHALL drive entry_idx_o = entry_cnt.
REQ-018 In GATHER, each cycle SHALL write entry_i into word_buf[3*slot+2 : 3*slot], then increment entry_cnt and slot.
REQ-019 GATHER SHALL go to WRITE when slot reaches ENTRIES_PER_WORD-1 or entry_cnt reaches NR_ENTRIES-1.
REQ-020 Unused word_buf bits SHALL be 0; this covers bit 63 and the unfilled slots of the last word.
REQ-021 In WRITE, the block SHALL drive data_req=1, data_we=1, data_be=8'hFF, data_size=2'b11, data_wdata=word_buf, kill_req=0 and tag_valid=1.
REQ-022 In WRITE, address_index and address_tag SHALL be split from addr = base + 8*word_cnt, with the sum taken modulo 2^64.
REQ-023 WRITE SHALL hold all request fields stable until data_gnt is sampled high.
REQ-024 On grant, word_cnt SHALL increment, slot and word_buf SHALL clear, and the next state is GATHER, or DONE if entry_cnt == NR_ENTRIES.
REQ-025 DONE SHALL assert done_o for exactly one cycle and then go to IDLE.
REQ-026 The number of words SHALL be ceil(NR_ENTRIES/ENTRIES_PER_WORD), which is 49 by default, with 16 valid slots in the last word.
REQ-027 With grant in the same cycle as the request, a checkpoint SHALL take NR_ENTRIES + words cycles from the first GATHER cycle to DONE (1073 by default).
REQ-028 abort_i in GATHER or DONE SHALL return the FSM to IDLE on the next cycle with no done_o.
REQ-029 abort_i in WRITE SHALL be recorded and take effect on the grant cycle, going to IDLE; no outstanding request is ever dropped.
REQ-030 If abort_i and the final grant coincide, the abort SHALL win and done_o SHALL stay low.
REQ-031 Outside WRITE, dcache_req_o SHALL be all-zero.
REQ-032 Outside GATHER, entry_idx_o SHALL be 0.

Reset
REQ-033 While rst_ni is low at a clock edge: state=IDLE; counters, word_buf and the abort flag cleared; dcache_req_o='0; done_o=0; busy_o=0.
REQ-034 Reset in mid-WRITE SHALL drop data_req on the next edge; the D-cache is reset by the same signal.

Structure
REQ-035 CKPT_ENTRY_BITS=3, CKPT_ENTRIES_PER_WORD=21 and a bht_ckpt_state_e enum SHALL live in ariane_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; it sits between the BHT checkpoint read port and a D-cache store port.

Verification
REQ-037 Scenario "full checkpoint, immediate grant": all entries = 3'b110, base 0x8000_0000, gnt tied high.
  - Required: 49 stores at 0x8000_0000..0x8000_0180.
  - Words 0..47 = 63'h6DB6DB6DB6DB6DB6 pattern (bit 63 = 0); word 48 = 48 bits of the pattern.
  - done_o at cycle 1073 after GATHER entry.
REQ-038 Scenario "delayed grant": grant withheld 5 cycles per store. Required: request fields stable throughout; total cycles 1024+49*6; data identical to REQ-037.
REQ-039 Scenario "abort": abort_i in GATHER at entry 100 -> IDLE, no done_o, no further requests. abort_i in WRITE of word 3 -> IDLE only after that grant, 4 stores total.
REQ-040 Scenario "start while busy": start_i pulsed mid-GATHER -> ignored; word count and addresses unchanged.
REQ-041 Scenario "unaligned base": base 0x1007 -> first address 0x1000.
REQ-042 Scenario "reset mid-write": rst_ni low during WRITE -> data_req=0 and IDLE the next cycle; a subsequent start_i produces a complete, correct checkpoint.
